// File: rtl/alu_rr_sched_if.sv
// Request/grant/result bundle between two requesters and the shared ALU scheduler.
interface alu_rr_sched_if #(
  parameter int op_size = 4
);
  logic               req0;
  logic [2:0]         op0;
  logic [op_size-1:0] a0;
  logic [op_size-1:0] b0;
  logic               req1;
  logic [2:0]         op1;
  logic [op_size-1:0] a1;
  logic [op_size-1:0] b1;
  logic               gnt0;
  logic               gnt1;
  logic               done0;
  logic               done1;
  logic               err;
  logic               busy;
  logic [op_size-1:0] result;
  logic [3:0]         ccr;

  // Requester side: drives requests and operands, observes handshake and results.
  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  gnt0, gnt1, done0, done1, err, busy, result, ccr
  );

  // Scheduler side.
  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output gnt0, gnt1, done0, done1, err, busy, result, ccr
  );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU between two requesters. Each accepted
// operation walks IDLE -> EXEC -> FLAGS -> RESP; the CVNZ register persists
// across operations and is only cleared by reset.
module alu_rr_sched #(
  parameter int         op_size = 4,
  parameter logic [3:0] c_mask  = 4'b1000,
  parameter logic [3:0] v_mask  = 4'b0100,
  parameter logic [3:0] n_mask  = 4'b0010,
  parameter logic [3:0] z_mask  = 4'b0001
) (
  input logic           clk,
  input logic           rst,
  alu_rr_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, FLAGS, RESP} state_t;

  state_t             state, state_nxt;
  logic               owner;        // 0: requester 0, 1: requester 1
  logic               last_served;
  logic [2:0]         op_q;
  logic [op_size-1:0] a_q, b_q;
  logic [op_size-1:0] result_q;
  logic [3:0]         ccr_q;

  logic               grant, win1, illegal;
  logic [op_size:0]   sum;
  logic [op_size-1:0] diff;
  logic [op_size-1:0] alu_r;
  logic               alu_c, alu_v;

  // Arbitration: a lone request wins; on a tie the side not served last wins.
  always_comb begin
    grant = (state == IDLE) && (bus.req0 || bus.req1);
    win1  = bus.req1 && (!bus.req0 || !last_served);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: fixed phase sequence, no stalls.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = EXEC;
      EXEC:    state_nxt = FLAGS;
      FLAGS:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: grant shown during EXEC, done/err during RESP, both tagged by owner.
  always_comb begin
    bus.busy   = (state != IDLE);
    bus.gnt0   = (state == EXEC) && !owner;
    bus.gnt1   = (state == EXEC) &&  owner;
    bus.done0  = (state == RESP) && !owner;
    bus.done1  = (state == RESP) &&  owner;
    bus.err    = (state == RESP) && illegal;
    bus.result = result_q;
    bus.ccr    = ccr_q;
  end

  // ALU on the latched operands. C and V default to their held values so the
  // logic ops leave them untouched.
  always_comb begin
    illegal = (op_q[2:1] == 2'b11);
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    alu_r   = result_q;
    alu_c   = |(ccr_q & c_mask);
    alu_v   = |(ccr_q & v_mask);
    case (op_q)
      3'b000: begin
        alu_r = sum[op_size-1:0];
        alu_c = sum[op_size];
        alu_v = (a_q[op_size-1] == b_q[op_size-1]) && (sum[op_size-1] != a_q[op_size-1]);
      end
      3'b001: begin
        alu_r = diff;
        alu_c = (a_q < b_q);
        alu_v = (a_q[op_size-1] != b_q[op_size-1]) && (diff[op_size-1] != a_q[op_size-1]);
      end
      3'b010:  alu_r = a_q & b_q;
      3'b011:  alu_r = a_q | b_q;
      3'b100:  alu_r = a_q ^ b_q;
      3'b101:  alu_r = ~a_q;
      default: alu_r = result_q;
    endcase
  end

  // Operand latch at grant, result/C/V at EXEC, N/Z at FLAGS; illegal ops touch nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      ccr_q       <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          owner       <= win1;
          last_served <= win1;
          op_q        <= win1 ? bus.op1 : bus.op0;
          a_q         <= win1 ? bus.a1  : bus.a0;
          b_q         <= win1 ? bus.b1  : bus.b0;
        end
        EXEC: if (!illegal) begin
          result_q <= alu_r;
          ccr_q    <= (ccr_q & ~(c_mask | v_mask)) |
                      (alu_c ? c_mask : 4'b0000) |
                      (alu_v ? v_mask : 4'b0000);
        end
        FLAGS: if (!illegal) begin
          ccr_q <= (ccr_q & ~(n_mask | z_mask)) |
                   (result_q[op_size-1] ? n_mask : 4'b0000) |
                   ((result_q == '0)    ? z_mask : 4'b0000);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed scenarios plus randomized ops
// compared against an arithmetic reference model of the ALU and CVNZ rules.
module tb_alu_rr_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rr_sched_if #(.op_size(4)) bus ();

  alu_rr_sched #(.op_size(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] m_res;
  logic [3:0] m_ccr;
  bit         m_last;

  // Observations from the most recent issue
  int         g_lat, d_lat;
  bit         g_who, d_who, e_o, ovl;
  logic [3:0] r_o, c_o;

  function automatic int sval(input logic [3:0] x);
    return (x >= 4'd8) ? int'(x) - 16 : int'(x);
  endfunction

  // Apply one operation to the model using plain integer arithmetic.
  function automatic void model_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int r, s;
    case (op)
      3'd0: begin r = int'(a) + int'(b); m_ccr[3] = (r > 15); s = sval(a) + sval(b); m_ccr[2] = (s > 7 || s < -8); end
      3'd1: begin r = int'(a) - int'(b); m_ccr[3] = (a < b);  s = sval(a) - sval(b); m_ccr[2] = (s > 7 || s < -8); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = int'(~a);
      default: return;
    endcase
    m_res    = r[3:0];
    m_ccr[1] = (m_res >= 4'd8);
    m_ccr[0] = (m_res == 4'd0);
  endfunction

  function automatic void model_reset();
    m_res  = 4'd0;
    m_ccr  = 4'd0;
    m_last = 1'b1;
  endfunction

  task automatic clear_inputs();
    bus.req0 = 0; bus.op0 = 0; bus.a0 = 0; bus.b0 = 0;
    bus.req1 = 0; bus.op1 = 0; bus.a1 = 0; bus.b1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one request from a negedge in IDLE, record grant/done timing and
  // the response; returns one negedge after done so the DUT is back in IDLE.
  task automatic issue(input bit who, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input bit scramble);
    g_lat = -1; d_lat = -1; g_who = 0; d_who = 0; e_o = 0; ovl = 0; r_o = 'x; c_o = 'x;
    if (!who) begin bus.req0 = 1; bus.op0 = op; bus.a0 = a; bus.b0 = b; end
    else      begin bus.req1 = 1; bus.op1 = op; bus.a1 = a; bus.b1 = b; end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        g_lat = i; g_who = bus.gnt1; ovl = bus.gnt0 && bus.gnt1;
        break;
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    if (scramble) begin
      bus.op0 = 3'($urandom); bus.a0 = 4'($urandom); bus.b0 = 4'($urandom);
      bus.op1 = 3'($urandom); bus.a1 = 4'($urandom); bus.b1 = 4'($urandom);
    end
    if (g_lat < 0) return;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        d_lat = g_lat + j; d_who = bus.done1; ovl = ovl || (bus.done0 && bus.done1);
        e_o = bus.err; r_o = bus.result; c_o = bus.ccr;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.req0 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err});
    end
    checks++;
    if (bus.result !== 4'd0 || bus.ccr !== 4'd0) begin
      errors++; $display("FAIL reset_data: result=%b ccr=%b want 0000 0000", bus.result, bus.ccr);
    end
    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_directed();
    issue(0, 3'b000, 4'b0111, 4'b0001, 0); model_op(3'b000, 4'b0111, 4'b0001);
    checks++;
    if (g_lat !== 1 || g_who !== 0) begin errors++; $display("FAIL add_gnt: lat=%0d who=%0d want 1 0", g_lat, g_who); end
    checks++;
    if (d_lat !== 3 || d_who !== 0 || ovl) begin errors++; $display("FAIL add_done: lat=%0d who=%0d want 3 0", d_lat, d_who); end
    checks++;
    if (r_o !== 4'b1000 || c_o !== 4'b0110 || e_o !== 0) begin
      errors++; $display("FAIL add_data: r=%b ccr=%b err=%b want 1000 0110 0", r_o, c_o, e_o);
    end

    issue(0, 3'b001, 4'b0011, 4'b0101, 0); model_op(3'b001, 4'b0011, 4'b0101);
    checks++;
    if (r_o !== 4'b1110 || c_o !== 4'b1010 || e_o !== 0) begin
      errors++; $display("FAIL sub_data: r=%b ccr=%b err=%b want 1110 1010 0", r_o, c_o, e_o);
    end

    issue(1, 3'b110, 4'b1111, 4'b1111, 0); model_op(3'b110, 4'b1111, 4'b1111);
    checks++;
    if (e_o !== 1 || d_who !== 1 || d_lat !== 3) begin
      errors++; $display("FAIL illegal_err: err=%b who=%0d lat=%0d want 1 1 3", e_o, d_who, d_lat);
    end
    checks++;
    if (r_o !== 4'b1110 || c_o !== 4'b1010) begin
      errors++; $display("FAIL illegal_hold: r=%b ccr=%b want 1110 1010", r_o, c_o);
    end

    issue(1, 3'b101, 4'b1111, 4'b0110, 0); model_op(3'b101, 4'b1111, 4'b0110);
    checks++;
    if (r_o !== 4'b0000 || c_o !== 4'b1001 || e_o !== 0 || d_who !== 1) begin
      errors++; $display("FAIL not_data: r=%b ccr=%b err=%b who=%0d want 0000 1001 0 1", r_o, c_o, e_o, d_who);
    end
  endtask

  task automatic test_latch();
    issue(0, 3'b010, 4'b0001, 4'b0011, 0);
    model_op(3'b010, 4'b0001, 4'b0011);
    // Second op: operands scrambled right after gnt must not matter.
    bus.req0 = 1; bus.op0 = 3'b010; bus.a0 = 4'b0001; bus.b0 = 4'b0011;
    g_lat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.gnt0) begin g_lat = i; break; end
    end
    bus.req0 = 0; bus.a0 = 4'b1111; bus.b0 = 4'b0000; bus.op0 = 3'b011;
    d_lat = -1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (bus.done0) begin d_lat = j; r_o = bus.result; c_o = bus.ccr; break; end
    end
    @(negedge clk);
    model_op(3'b010, 4'b0001, 4'b0011);
    checks++;
    if (g_lat !== 1 || d_lat !== 2) begin errors++; $display("FAIL latch_timing: gnt=%0d done+%0d want 1 2", g_lat, d_lat); end
    checks++;
    if (r_o !== 4'b0001 || c_o !== m_ccr) begin
      errors++; $display("FAIL latch_data: r=%b ccr=%b want 0001 %b", r_o, c_o, m_ccr);
    end
  endtask

  task automatic test_back_to_back();
    bit win, got;
    do_reset();
    bus.req0 = 1; bus.op0 = 3'b000; bus.a0 = 4'b0001; bus.b0 = 4'b0001;
    bus.req1 = 1; bus.op1 = 3'b100; bus.a1 = 4'b0101; bus.b1 = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      win = !m_last; m_last = win;
      if (win) model_op(bus.op1, bus.a1, bus.b1); else model_op(bus.op0, bus.a0, bus.b0);
      g_lat = -1; got = 0;
      for (int i = 1; i <= 6; i++) begin
        @(negedge clk);
        if (bus.gnt0 || bus.gnt1) begin g_lat = i; got = bus.gnt1; ovl = bus.gnt0 && bus.gnt1; break; end
      end
      checks++;
      if (g_lat < 0 || got !== win || ovl) begin
        errors++; $display("FAIL rr_gnt%0d: lat=%0d who=%0d want who=%0d", k, g_lat, got, win);
      end
      d_lat = -1;
      for (int j = 1; j <= 6; j++) begin
        @(negedge clk);
        if (bus.done0 || bus.done1) begin
          d_lat = j; d_who = bus.done1; ovl = bus.done0 && bus.done1; r_o = bus.result; c_o = bus.ccr;
          break;
        end
      end
      if (k == 2) begin bus.req0 = 0; bus.req1 = 0; end
      checks++;
      if (d_lat !== 2 || d_who !== win || ovl || r_o !== m_res || c_o !== m_ccr) begin
        errors++; $display("FAIL rr_done%0d: lat=%0d who=%0d r=%b ccr=%b want 2 %0d %b %b",
          k, d_lat, d_who, r_o, c_o, win, m_res, m_ccr);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int seen;
    issue(0, 3'b000, 4'b0011, 4'b0011, 0); model_op(3'b000, 4'b0011, 4'b0011);
    bus.req0 = 1; bus.op0 = 3'b000; bus.a0 = 4'b0111; bus.b0 = 4'b0111;
    g_lat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.gnt0) begin g_lat = i; break; end
    end
    bus.req0 = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (g_lat !== 1 || {bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err} !== 6'b0 ||
        bus.result !== 4'd0 || bus.ccr !== 4'd0) begin
      errors++; $display("FAIL abort_state: gnt_lat=%0d busy=%b result=%b ccr=%b want 1 0 0000 0000",
        g_lat, bus.busy, bus.result, bus.ccr);
    end
    rst = 1'b0;
    model_reset();
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_quiet: active cycles=%0d want 0", seen); end
    issue(1, 3'b011, 4'b1010, 4'b0101, 0); model_op(3'b011, 4'b1010, 4'b0101);
    checks++;
    if (g_lat !== 1 || g_who !== 1 || d_lat !== 3 || d_who !== 1) begin
      errors++; $display("FAIL abort_next_hs: gnt=%0d/%0d done=%0d/%0d want 1/1 3/1", g_lat, g_who, d_lat, d_who);
    end
    checks++;
    if (r_o !== 4'b1111 || c_o !== 4'b0010) begin
      errors++; $display("FAIL abort_next_data: r=%b ccr=%b want 1111 0010", r_o, c_o);
    end
  endtask

  task automatic test_random();
    bit who; logic [2:0] op; logic [3:0] a, b;
    for (int n = 0; n < 40; n++) begin
      who = 1'($urandom); op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
      issue(who, op, a, b, 1);
      model_op(op, a, b);
      checks++;
      if (g_lat !== 1 || g_who !== who || d_lat !== 3 || d_who !== who || ovl) begin
        errors++; $display("FAIL rand%0d_hs: gnt=%0d/%0d done=%0d/%0d want 1/%0d 3/%0d",
          n, g_lat, g_who, d_lat, d_who, who, who);
      end
      checks++;
      if (e_o !== (op >= 3'd6)) begin errors++; $display("FAIL rand%0d_err: op=%b err=%b", n, op, e_o); end
      checks++;
      if (r_o !== m_res || c_o !== m_ccr) begin
        errors++; $display("FAIL rand%0d_data: op=%b a=%b b=%b r=%b ccr=%b want %b %b",
          n, op, a, b, r_o, c_o, m_res, m_ccr);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_directed();
    test_latch();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
